operand_reg_bank: RTL and testbench

- Parametrised operand register bank for the ALU front panel.
- Holds NUM_CH independent WIDTH-bit operand registers, loaded from switches by a debounced load button, one channel at a time via a channel select.
- Replaces the per-operand latch registers with one clocked, synchronised, debounced block.
- Feeds the ALU operand inputs and the display logic.

---
 rtl/operand_reg_bank.sv | 171 +++++++++++++++++
 tb/tb_operand_reg_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/operand_reg_bank.sv
// operand_reg_bank: NUM_CH operand registers for the ALU front panel.
// Switch data and channel select are synchronised; the load and clear
// buttons are synchronised, debounced and edge-detected, so each press
// produces exactly one action on the selected channel. Requests are
// staged through one register so that every output comes from a flop.
module operand_reg_bank #(
  parameter int WIDTH     = 4,
  parameter int NUM_CH    = 2,
  parameter int DB_CYCLES = 1000000,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    btnC,
  input  logic [WIDTH-1:0]        sw,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    btnL,
  input  logic                    btnR,
  output logic [NUM_CH*WIDTH-1:0] regs,
  output logic [NUM_CH-1:0]       valid,
  output logic                    load_pulse,
  output logic                    sel_err
);

  // Debounce counter sizing and terminal count.
  localparam int               CNT_W   = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // One extra bit so selects at or beyond NUM_CH compare correctly.
  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  // Button index 0 is load (btnL), index 1 is clear (btnR).
  logic [1:0] btn_raw;
  assign btn_raw = {btnR, btnL};

  // Two-flop synchroniser stages.
  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_sync;
  logic [SEL_W-1:0] sel_meta;
  logic [SEL_W-1:0] sel_sync;
  logic [1:0]       btn_meta;
  logic [1:0]       btn_sync;

  // Debounce state per button.
  logic [1:0][CNT_W-1:0] db_cnt;
  logic [1:0][CNT_W-1:0] db_cnt_nxt;
  logic [1:0]            db_level;
  logic [1:0]            db_level_nxt;
  logic [1:0]            db_prev;

  // Edge-detected requests and select range check.
  logic req_load;
  logic req_clear;
  logic sel_ok;

  // Request stage: captured select/data and pending clear.
  logic [SEL_W-1:0] op_sel;
  logic [WIDTH-1:0] op_data;
  logic             clear_go;

  // Next state of the register bank.
  logic [NUM_CH*WIDTH-1:0] regs_nxt;
  logic [NUM_CH-1:0]       valid_nxt;

  // Synchronise all asynchronous panel inputs into the clk domain.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sel_meta <= '0;
      sel_sync <= '0;
      btn_meta <= 2'b00;
      btn_sync <= 2'b00;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      sel_meta <= sel;
      sel_sync <= sel_meta;
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: count cycles of disagreement, toggle the level at terminal count.
  always_comb begin
    db_cnt_nxt   = db_cnt;
    db_level_nxt = db_level;
    for (int b = 0; b < 2; b++) begin
      if (btn_sync[b] == db_level[b]) begin
        db_cnt_nxt[b] = '0;
      end else if (db_cnt[b] == CNT_MAX) begin
        db_level_nxt[b] = ~db_level[b];
        db_cnt_nxt[b]   = '0;
      end else begin
        db_cnt_nxt[b] = db_cnt[b] + CNT_ONE;
      end
    end
  end

  // Debounce and edge-history registers.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      db_cnt   <= '0;
      db_level <= 2'b00;
      db_prev  <= 2'b00;
    end else begin
      db_cnt   <= db_cnt_nxt;
      db_level <= db_level_nxt;
      db_prev  <= db_level;
    end
  end

  // Rising edges of the debounced levels become single-cycle requests.
  always_comb begin
    req_load  = db_level[0] & ~db_prev[0];
    req_clear = db_level[1] & ~db_prev[1];
    sel_ok    = ({1'b0, sel_sync} < NUM_CH_W);
  end

  // Stage the request: clear beats load, out-of-range selects only flag an error.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      load_pulse <= 1'b0;
      clear_go   <= 1'b0;
      sel_err    <= 1'b0;
      op_sel     <= '0;
      op_data    <= '0;
    end else begin
      load_pulse <= req_load & ~req_clear & sel_ok;
      clear_go   <= req_clear & sel_ok;
      sel_err    <= (req_load | req_clear) & ~sel_ok;
      op_sel     <= sel_sync;
      op_data    <= sw_sync;
    end
  end

  // Apply a staged clear or load to the selected channel only.
  always_comb begin
    regs_nxt  = regs;
    valid_nxt = valid;
    for (int k = 0; k < NUM_CH; k++) begin
      if (op_sel == SEL_W'(k)) begin
        if (clear_go) begin
          regs_nxt[k*WIDTH +: WIDTH] = '0;
          valid_nxt[k]               = 1'b0;
        end else if (load_pulse) begin
          regs_nxt[k*WIDTH +: WIDTH] = op_data;
          valid_nxt[k]               = 1'b1;
        end else begin
          regs_nxt[k*WIDTH +: WIDTH] = regs[k*WIDTH +: WIDTH];
          valid_nxt[k]               = valid[k];
        end
      end else begin
        regs_nxt[k*WIDTH +: WIDTH] = regs[k*WIDTH +: WIDTH];
        valid_nxt[k]               = valid[k];
      end
    end
  end

  // Operand registers and valid flags.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      regs  <= '0;
      valid <= '0;
    end else begin
      regs  <= regs_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_operand_reg_bank.sv
// Directed bench for operand_reg_bank with WIDTH=4, NUM_CH=3, DB_CYCLES=4.
module tb_operand_reg_bank;

  logic        clk = 1'b0;
  logic        btnC;
  logic [3:0]  sw;
  logic [1:0]  sel;
  logic        btnL;
  logic        btnR;
  logic [11:0] regs;
  logic [2:0]  valid;
  logic        load_pulse;
  logic        sel_err;

  int checks = 0;
  int errors = 0;
  int lp_count = 0;
  int se_count = 0;
  int base_lp;
  int base_se;

  operand_reg_bank #(
    .WIDTH(4),
    .NUM_CH(3),
    .DB_CYCLES(4)
  ) dut (
    .clk(clk),
    .btnC(btnC),
    .sw(sw),
    .sel(sel),
    .btnL(btnL),
    .btnR(btnR),
    .regs(regs),
    .valid(valid),
    .load_pulse(load_pulse),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Count strobe cycles as seen at each rising edge.
  always @(posedge clk) begin
    if (load_pulse === 1'b1) lp_count <= lp_count + 1;
    if (sel_err === 1'b1)    se_count <= se_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    btnC = 1'b1;
    btnL = 1'b0;
    btnR = 1'b0;
    sw   = 4'h0;
    sel  = 2'd0;
    #1;
    chk("reset_regs",  regs,       32'h0);
    chk("reset_valid", valid,      32'h0);
    chk("reset_lp",    load_pulse, 32'h0);
    chk("reset_err",   sel_err,    32'h0);
    cyc(3);
    btnC = 1'b0;
    cyc(2);

    // Basic load of channel 1 with A, latency 2 + 4 + 1 edges.
    sel = 2'd1; sw = 4'hA;
    cyc(3);
    base_lp = lp_count;
    btnL = 1'b1;
    cyc(6);
    chk("load_lat_early", load_pulse, 32'h0);
    cyc(1);
    chk("load_lat", load_pulse, 32'h1);
    chk("regs_before_commit", regs, 32'h0);
    cyc(1);
    chk("load_regs",  regs,       32'h0A0);
    chk("load_valid", valid,      32'h2);
    chk("load_lp_end", load_pulse, 32'h0);
    cyc(12);
    chk("load_once", lp_count - base_lp, 32'h1);
    btnL = 1'b0;
    cyc(12);
    chk("release_no_load", lp_count - base_lp, 32'h1);

    // Load channel 0 with 5 and channel 2 with 3.
    sel = 2'd0; sw = 4'h5;
    cyc(3);
    btnL = 1'b1; cyc(12); btnL = 1'b0; cyc(12);
    chk("ch0_regs",  regs,  32'h0A5);
    chk("ch0_valid", valid, 32'h3);
    sel = 2'd2; sw = 4'h3;
    cyc(3);
    btnL = 1'b1; cyc(12); btnL = 1'b0; cyc(12);
    chk("ch2_regs",  regs,  32'h3A5);
    chk("ch2_valid", valid, 32'h7);

    // Bounce on btnL: 2 high / 2 low repeated, then held high.
    sel = 2'd2; sw = 4'hC;
    cyc(3);
    base_lp = lp_count;
    for (int i = 0; i < 4; i++) begin
      btnL = 1'b1; cyc(2);
      btnL = 1'b0; cyc(2);
    end
    cyc(4);
    chk("bounce_no_load", lp_count - base_lp, 32'h0);
    chk("bounce_regs",    regs,               32'h3A5);
    btnL = 1'b1;
    cyc(12);
    chk("bounce_one_load", lp_count - base_lp, 32'h1);
    chk("bounce_regs_after", regs,             32'hCA5);
    chk("bounce_valid",      valid,            32'h7);
    btnL = 1'b0;
    cyc(12);

    // Load and clear on the same cycle: clear wins.
    sel = 2'd0;
    cyc(3);
    base_lp = lp_count;
    btnL = 1'b1; btnR = 1'b1;
    cyc(12);
    chk("prio_no_lp", lp_count - base_lp, 32'h0);
    chk("prio_regs",  regs,               32'hCA0);
    chk("prio_valid", valid,              32'h6);
    btnL = 1'b0; btnR = 1'b0;
    cyc(12);

    // Out-of-range select.
    sel = 2'd3; sw = 4'hF;
    cyc(3);
    base_lp = lp_count;
    base_se = se_count;
    btnL = 1'b1;
    cyc(12);
    chk("oor_err_once", se_count - base_se, 32'h1);
    chk("oor_no_lp",    lp_count - base_lp, 32'h0);
    chk("oor_regs",     regs,               32'hCA0);
    chk("oor_valid",    valid,              32'h6);
    btnL = 1'b0;
    cyc(12);

    // Reset in the middle of a debounce, then count restarts.
    sel = 2'd1; sw = 4'h7;
    cyc(3);
    btnL = 1'b1;
    cyc(5);
    chk("mid_db_no_lp", load_pulse, 32'h0);
    btnC = 1'b1;
    #1;
    chk("async_rst_regs",  regs,       32'h0);
    chk("async_rst_valid", valid,      32'h0);
    chk("async_rst_lp",    load_pulse, 32'h0);
    cyc(2);
    btnC = 1'b0;
    cyc(6);
    chk("post_rst_lat_early", load_pulse, 32'h0);
    cyc(1);
    chk("post_rst_lat", load_pulse, 32'h1);
    cyc(1);
    chk("post_rst_regs",  regs,  32'h070);
    chk("post_rst_valid", valid, 32'h2);
    btnL = 1'b0;
    cyc(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
